// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - write/read port bundle for the multi-read-port register file
interface regfile_mp_if #(
    parameter int XLEN  = 32,
    parameter int AW    = 5,
    parameter int NREAD = 2
);
    logic                  WE3;
    logic [AW-1:0]         A3;
    logic [XLEN-1:0]       WD3;
    logic [NREAD-1:0]      RE;
    logic [NREAD*AW-1:0]   RA;
    logic [NREAD*XLEN-1:0] RD;
    logic                  BUSY;

    modport master (output WE3, A3, WD3, RE, RA, input RD, BUSY);
    modport slave  (input WE3, A3, WD3, RE, RA, output RD, BUSY);
endinterface

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - one-write, NREAD-read register file with post-reset clear sweep
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 32,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic         CLK,
    input  logic         RST,
    regfile_mp_if.slave  bus
);
    localparam int AW = ($clog2(DEPTH) < 1) ? 1 : $clog2(DEPTH);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic [NREAD*XLEN-1:0] rd_q, rd_d;
    logic [XLEN-1:0]       mem_q [DEPTH];

    logic                  we_eff;
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [XLEN-1:0]       wr_data;

    function automatic logic in_range(input logic [AW-1:0] a);
        return 32'(a) < 32'(DEPTH);
    endfunction

    // The sweep borrows the single write port, so user writes only land in RUN.
    always_comb begin
        we_eff  = bus.WE3 && !busy_q && in_range(bus.A3)
                  && !((ZERO_REG != 0) && (bus.A3 == '0));
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_addr = bus.A3;
        wr_data = bus.WD3;
        if (state_q == CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = cnt_q;
            wr_data = '0;
            cnt_d   = cnt_q + 1'b1;
            if (32'(cnt_q) == 32'(DEPTH - 1)) begin
                state_d = RUN;
            end
        end else begin
            wr_en = we_eff;
        end
        busy_d = (state_d == CLEAR);
    end

    always_comb begin
        rd_d = rd_q;
        for (int i = 0; i < NREAD; i++) begin
            if (busy_q) begin
                rd_d[i*XLEN +: XLEN] = '0;
            end else if (bus.RE[i]) begin
                if (((ZERO_REG != 0) && (bus.RA[i*AW +: AW] == '0))
                    || !in_range(bus.RA[i*AW +: AW])) begin
                    rd_d[i*XLEN +: XLEN] = '0;
                end else if ((BYPASS != 0) && we_eff
                             && (bus.RA[i*AW +: AW] == bus.A3)) begin
                    rd_d[i*XLEN +: XLEN] = bus.WD3;
                end else begin
                    rd_d[i*XLEN +: XLEN] = mem_q[bus.RA[i*AW +: AW]];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            rd_q    <= rd_d;
        end
    end

    // Storage has no reset of its own; the sweep is what zeroes it.
    always_ff @(posedge CLK) begin
        if (!RST && wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign bus.RD   = rd_q;
    assign bus.BUSY = busy_q;
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file for the core's decode/register-read stage, generalising the existing two-read/one-write file. It has one write port, NREAD registered read ports with per-port read enable, and optional write-to-read bypass. Register 0 can optionally be hardwired to zero. After reset, a sweep state machine clears every entry so that no register ever reads an unknown value.

## Interface
- XLEN, 32: data width in bits.
- DEPTH, 32: number of registers (2..256; need not be a power of two).
- NREAD, 2: number of read ports (1..4).
- ZERO_REG, 1: 1 = register 0 always reads 0 and ignores writes.
- BYPASS, 1: 1 = same-cycle write data forwarded to a matching read; 0 = read returns old contents.
- Derived localparam AW = max(1, clog2(DEPTH)).

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- WE3  in  1  write enable.
- A3  in  AW  write address.
- WD3  in  XLEN  write data.
- RE  in  NREAD  per-port read enable; bit i belongs to port i.
- RA  in  NREAD*AW  packed read addresses; port i uses RA[i*AW +: AW].
- RD  out  NREAD*XLEN  packed registered read data; port i uses RD[i*XLEN +: XLEN].
- BUSY  out  1  high while reset or the clear sweep is in progress.

## Operation
- State machine: CLEAR and RUN. RST=1 forces CLEAR with the sweep counter at 0, on every edge it is sampled.
- CLEAR with RST=0:
  - Each edge writes 0 to mem[counter] and increments the counter.
  - The edge that clears entry DEPTH-1 moves the state to RUN.
- BUSY = (state == CLEAR), registered.
- While BUSY=1:
  - WE3 is ignored.
  - All RD ports load 0 on every edge, regardless of RE.
- Effective write: WEeff = WE3 & ~BUSY & (A3 < DEPTH) & ~(ZERO_REG & A3==0).
- In RUN, at each edge, for each port i with RE[i]=1, RD_i loads the first matching case:
  - (ZERO_REG & RA_i==0) or RA_i >= DEPTH: 0.
  - BYPASS & WEeff & RA_i==A3: WD3.
  - Otherwise: mem[RA_i] (pre-edge contents).
- Port i with RE[i]=0 holds its previous RD value.
- Any number of ports may read the same address in the same cycle. All receive identical data.
- Out-of-range addresses (DEPTH not a power of two):
  - A write to such an address is dropped silently.
  - A read of such an address returns 0.
- With ZERO_REG=0, register 0 is an ordinary register.

## Timing
- Reset values:
  - RD = 0 on all ports.
  - BUSY = 1.
  - State CLEAR, sweep counter 0.
  - Memory contents are not directly reset. They are zeroed by the sweep.
- RST high for any number of cycles keeps BUSY=1. Reasserting RST mid-sweep restarts the sweep from entry 0.
- Sweep length: the first edge with RST=0 clears entry 0. BUSY falls after the DEPTH-th edge with RST=0 (32 edges at the default DEPTH).
- The first write is accepted on the first edge at which BUSY is sampled 0.
- Read latency: 1 cycle. The address and RE presented before edge n give RD valid after edge n.
- Write latency: 1 cycle.
  - A non-bypassed read of the written address in the same cycle (BYPASS=0) returns the old value.
  - A read of that address at edge n+1 returns the new value in all modes.
- No combinational path from any input to any output.

## Test plan
- Reset sweep: hold RST=1 for 3 cycles, then release.
  - BUSY stays 1 for exactly 32 edges after release, then falls.
  - Reading all 32 addresses afterwards returns 0.
  - Issue WE3=1, A3=5, WD3=0xDEADBEEF during the sweep: after BUSY falls, mem[5] still reads 0.
- Write/read with bypass, default parameters: WE3=1, A3=7, WD3=0x12345678 with RA0=7, RA1=7, RE=2'b11 in the same cycle.
  - Both RD ports show 0x12345678 after that edge.
  - Rerun with BYPASS=0: both show 0 after that edge, and 0x12345678 one cycle later.
- Zero register: write 0xFFFFFFFF to A3=0, then read RA0=0.
  - With ZERO_REG=1, RD0 = 0.
  - With ZERO_REG=0, RD0 = 0xFFFFFFFF.
- Read enable hold: RD1 holds 0xA5A5A5A5 from a prior read. Set RE[1]=0 and switch RA1 to a register holding 0x1.
  - RD1 stays 0xA5A5A5A5.
  - Set RE[1]=1: RD1 = 0x1 after the next edge.
- Odd depth, DEPTH=24, NREAD=3: write 0x55 to A3=30, then read RA=30 on all three ports.
  - Every port returns 0.
  - Sweep length is 24 edges.
- Mid-sweep reset: assert RST at the 10th sweep edge.
  - BUSY stays high.
  - The sweep restarts at entry 0, and BUSY falls exactly DEPTH edges after RST is released.
